// File: rtl/fetch_line_buf.sv
// ============================================================================
// Module   : fetch_line_buf
// Brief    : Single-line instruction fetch buffer. Hits return in one cycle;
//            a miss stalls the PC and refills the whole line with a burst read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_line_buf #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pc_valid,
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_instr_valid,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_instr_addr,
  output logic              o_mem_rd_valid,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic              i_mem_rd_ready,
  input  logic              i_mem_rdata_valid,
  input  logic [31:0]       i_mem_rdata
);

  localparam int c_OFF = $clog2(LINE_WORDS);
  localparam int c_TAG_W = ADDR_W - c_OFF - 2;
  localparam logic [c_OFF-1:0] c_LAST = c_OFF'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_READY     = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_FILL = 2'd2,
    S_DELIVER   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_line_valid;
  logic [c_TAG_W-1:0] r_tag;
  logic [31:0]        r_data [LINE_WORDS];
  logic               r_flush_pend;
  logic [c_OFF-1:0]   r_cnt;
  logic [c_TAG_W-1:0] r_miss_tag;
  logic [c_OFF-1:0]   r_miss_off;
  logic               r_instr_valid;
  logic [31:0]        r_instr;
  logic [ADDR_W-1:0]  r_instr_addr;

  logic [c_TAG_W-1:0] w_pc_tag;
  logic [c_OFF-1:0]   w_pc_off;
  logic               w_hit;
  logic               w_last_beat;
  logic [31:0]        w_fill_word;
  logic               w_stall;
  logic               w_mem_rd_valid;
  logic               w_unused_lsb;

  assign w_pc_tag     = i_pc_addr[ADDR_W-1:c_OFF+2];
  assign w_pc_off     = i_pc_addr[c_OFF+1:2];
  assign w_unused_lsb = ^i_pc_addr[1:0];
  // A flush in the same cycle as a request forces that request to miss.
  assign w_hit        = r_line_valid & ~i_flush & (r_tag == w_pc_tag);
  assign w_last_beat  = i_mem_rdata_valid & (r_cnt == c_LAST);
  // The requested word may be arriving on the final beat itself.
  assign w_fill_word  = (r_miss_off == r_cnt) ? i_mem_rdata : r_data[r_miss_off];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_READY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_stall        = 1'b0;
    w_mem_rd_valid = 1'b0;
    case (r_state)
      S_READY: begin
        if (i_pc_valid && !w_hit) begin
          w_next  = S_MISS_REQ;
          w_stall = 1'b1;
        end
      end
      S_MISS_REQ: begin
        w_stall        = 1'b1;
        w_mem_rd_valid = 1'b1;
        if (i_mem_rd_ready) w_next = S_MISS_FILL;
      end
      S_MISS_FILL: begin
        w_stall = 1'b1;
        if (w_last_beat) w_next = S_DELIVER;
      end
      S_DELIVER: w_next = S_READY;
      default:   w_next = S_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_valid  <= 1'b0;
      r_tag         <= '0;
      r_flush_pend  <= 1'b0;
      r_cnt         <= '0;
      r_miss_tag    <= '0;
      r_miss_off    <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_addr  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        S_READY: begin
          if (i_flush) r_line_valid <= 1'b0;
          if (i_pc_valid) begin
            if (w_hit) begin
              r_instr_valid <= 1'b1;
              r_instr       <= r_data[w_pc_off];
              r_instr_addr  <= {i_pc_addr[ADDR_W-1:2], 2'b00};
            end else begin
              r_miss_tag <= w_pc_tag;
              r_miss_off <= w_pc_off;
            end
          end
        end
        S_MISS_REQ: begin
          r_cnt        <= '0;
          r_flush_pend <= r_flush_pend | i_flush;
        end
        S_MISS_FILL: begin
          r_flush_pend <= r_flush_pend | i_flush;
          if (i_mem_rdata_valid) begin
            r_data[r_cnt] <= i_mem_rdata;
            r_cnt         <= r_cnt + c_OFF'(1);
            if (r_cnt == c_LAST) begin
              r_tag         <= r_miss_tag;
              r_line_valid  <= 1'b1;
              r_instr_valid <= 1'b1;
              r_instr       <= w_fill_word;
              r_instr_addr  <= {r_miss_tag, r_miss_off, 2'b00};
            end
          end
        end
        S_DELIVER: begin
          // A flush seen during the refill takes effect only once delivered.
          if (r_flush_pend || i_flush) r_line_valid <= 1'b0;
          r_flush_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_stall        = w_stall;
  assign o_instr_valid  = r_instr_valid;
  assign o_instr        = r_instr;
  assign o_instr_addr   = r_instr_addr;
  assign o_mem_rd_valid = w_mem_rd_valid;
  assign o_mem_rd_addr  = {r_miss_tag, {(c_OFF+2){1'b0}}};

endmodule

`default_nettype wire
